frogger_game_sequencer: RTL

- Top-level game controller for the Frogger datapath.
- Consumes the per-cycle flags produced by the register comparator (lose, level-won, frog-nested) and sequences the game through start, play, death, nest, level-up, game-over and win.
- Drives clear/reload pulses to the background (obstacle) and point (frog) registers, a run enable, and level, lives and speed outputs.
- Sits between the comparator and the register/prescaler blocks.

---
 rtl/frogger_game_pkg.sv | 41 ++++
 rtl/frogger_game_if.sv | 39 +++
 rtl/frogger_game_sequencer_dwell.sv | 31 +++
 rtl/frogger_game_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/frogger_game_pkg.sv
// frogger_game_pkg: shared state codes, event priority and default constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frogger_game_pkg;

  // State codes are also shown on the display, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_DEAD  = 3'd3,
    ST_NEST  = 3'd4,
    ST_LEVEL = 3'd5,
    ST_OVER  = 3'd6,
    ST_WIN   = 3'd7
  } state_t;

  // PLAY-state event, listed in priority order: lose beats winLevel beats nest.
  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_LOSE = 2'd1,
    EVT_WIN  = 2'd2,
    EVT_NEST = 2'd3
  } evt_t;

  localparam int DEFAULT_BASE_SPEED  = 200;
  localparam int DEFAULT_SPEED_STEP  = 40;
  localparam int DEFAULT_MIN_SPEED   = 40;
  localparam int DEFAULT_DWELL_TICKS = 8;

  // Prescaler reload for a level, evaluated at 9 bits signed and floored.
  function automatic logic [7:0] speed_for_level(input int lvl, input int base,
                                                 input int step, input int floor_v);
    logic signed [8:0] s;
    s = 9'(base - lvl * step);
    if (s < $signed(9'(floor_v)))
      return 8'(floor_v);
    return 8'(s);
  endfunction

endpackage

// File: rtl/frogger_game_if.sv
// frogger_game_if: comparator flags in, register/prescaler controls out.
// Latency: n/a (wiring only).
// Backpressure: none; flags are levels, controls are pulses/levels.
// master = sequencer side, slave = datapath side.
interface frogger_game_if #(
  parameter int LEVEL_W = 2,
  parameter int LIVES_W = 2
);
  logic               GAMESEQ_start_InLow;
  logic               GAMESEQ_tick_InHigh;
  logic               GAMESEQ_lose_InHigh;
  logic               GAMESEQ_winLevel_InHigh;
  logic               GAMESEQ_nest_InHigh;
  logic               GAMESEQ_clearBack_OutHigh;
  logic               GAMESEQ_clearPoint_OutHigh;
  logic               GAMESEQ_run_OutHigh;
  logic [LEVEL_W-1:0] GAMESEQ_level_Out;
  logic [LIVES_W-1:0] GAMESEQ_lives_Out;
  logic [7:0]         GAMESEQ_speed_Out;
  logic [2:0]         GAMESEQ_state_Out;
  logic               GAMESEQ_gameOver_OutHigh;
  logic               GAMESEQ_gameWin_OutHigh;

  modport master (
    input  GAMESEQ_start_InLow, GAMESEQ_tick_InHigh, GAMESEQ_lose_InHigh,
           GAMESEQ_winLevel_InHigh, GAMESEQ_nest_InHigh,
    output GAMESEQ_clearBack_OutHigh, GAMESEQ_clearPoint_OutHigh, GAMESEQ_run_OutHigh,
           GAMESEQ_level_Out, GAMESEQ_lives_Out, GAMESEQ_speed_Out, GAMESEQ_state_Out,
           GAMESEQ_gameOver_OutHigh, GAMESEQ_gameWin_OutHigh
  );

  modport slave (
    output GAMESEQ_start_InLow, GAMESEQ_tick_InHigh, GAMESEQ_lose_InHigh,
           GAMESEQ_winLevel_InHigh, GAMESEQ_nest_InHigh,
    input  GAMESEQ_clearBack_OutHigh, GAMESEQ_clearPoint_OutHigh, GAMESEQ_run_OutHigh,
           GAMESEQ_level_Out, GAMESEQ_lives_Out, GAMESEQ_speed_Out, GAMESEQ_state_Out,
           GAMESEQ_gameOver_OutHigh, GAMESEQ_gameWin_OutHigh
  );
endinterface

// File: rtl/frogger_game_sequencer_dwell.sv
// frogger_dwell_timer: counts tick pulses while not held in clear.
// Latency: done is combinational on the DWELL_TICKS-th counted tick.
// Backpressure: none; ticks during clear are dropped.
// Ports: clk, rst_n (async low), clear, tick in; done out.
module frogger_dwell_timer
  import frogger_game_pkg::*;
#(
  parameter int DWELL_TICKS = DEFAULT_DWELL_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic done
);
  localparam int CNT_W = $clog2(DWELL_TICKS + 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else if (clear)
      count_q <= '0;
    else if (tick)
      count_q <= count_q + CNT_W'(1);
  end

  assign done = tick && !clear && (count_q == CNT_W'(DWELL_TICKS - 1));

endmodule

// File: rtl/frogger_game_sequencer.sv
// frogger_game_sequencer: Frogger game FSM driving register clears, run, level/lives/speed.
// Latency: all outputs registered; an input event shows on outputs 1 cycle later, speed 1 more.
// Backpressure: none; flags are edge-detected, repeats while held are ignored.
// Ports: GAMESEQ_CLOCK_50, GAMESEQ_RESET_InLow (async low), gs (frogger_game_if.master).
// Build option: GAMESEQ_BONUS_LIFE_EN adds a life (up to MAX_LIVES) on every level-up.
module frogger_game_sequencer
  import frogger_game_pkg::*;
#(
  parameter int NUM_LEVELS  = 4,
  parameter int LEVEL_W     = 2,
  parameter int START_LIVES = 3,
  parameter int MAX_LIVES   = 3,
  parameter int LIVES_W     = 2,
  parameter int DWELL_TICKS = DEFAULT_DWELL_TICKS,
  parameter int BASE_SPEED  = DEFAULT_BASE_SPEED,
  parameter int SPEED_STEP  = DEFAULT_SPEED_STEP,
  parameter int MIN_SPEED   = DEFAULT_MIN_SPEED
) (
  input  logic GAMESEQ_CLOCK_50,
  input  logic GAMESEQ_RESET_InLow,
  frogger_game_if.master gs
);
  // Starting lives never exceed the ceiling.
  localparam int LIVES_INIT = (START_LIVES > MAX_LIVES) ? MAX_LIVES : START_LIVES;

  state_t             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [7:0]         speed_q;
  logic               clear_back_q, clear_back_d;
  logic               clear_point_q, clear_point_d;
  logic               run_q, over_q, win_q;
  logic               start_prev_q, lose_prev_q, win_prev_q, nest_prev_q;
  logic               dwell_armed_q;
  logic               start_ev, lose_ev, win_ev, nest_ev;
  logic               in_dwell, dwell_clear, dwell_done;
  evt_t               play_evt;

  assign start_ev = start_prev_q && !gs.GAMESEQ_start_InLow;
  assign lose_ev  = gs.GAMESEQ_lose_InHigh && !lose_prev_q;
  assign win_ev   = gs.GAMESEQ_winLevel_InHigh && !win_prev_q;
  assign nest_ev  = gs.GAMESEQ_nest_InHigh && !nest_prev_q;

  always_comb begin
    play_evt = EVT_NONE;
    if (lose_ev)     play_evt = EVT_LOSE;
    else if (win_ev) play_evt = EVT_WIN;
    else if (nest_ev) play_evt = EVT_NEST;
  end

  // The timer is held clear outside the dwell states and on the entry cycle,
  // so a tick coincident with entry is not counted.
  assign in_dwell    = (state_q == ST_DEAD) || (state_q == ST_LEVEL);
  assign dwell_clear = !(in_dwell && dwell_armed_q);

  frogger_dwell_timer #(.DWELL_TICKS(DWELL_TICKS)) u_dwell (
    .clk   (GAMESEQ_CLOCK_50),
    .rst_n (GAMESEQ_RESET_InLow),
    .clear (dwell_clear),
    .tick  (gs.GAMESEQ_tick_InHigh),
    .done  (dwell_done)
  );

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    lives_d       = lives_q;
    clear_back_d  = 1'b0;
    clear_point_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER, ST_WIN: begin
        if (start_ev) begin
          state_d = ST_LOAD;
          level_d = '0;
          lives_d = LIVES_W'(LIVES_INIT);
        end
      end
      ST_LOAD: state_d = ST_PLAY;
      ST_PLAY: begin
        case (play_evt)
          EVT_LOSE: begin
            state_d = ST_DEAD;
            lives_d = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
          end
          EVT_WIN:  state_d = ST_LEVEL;
          EVT_NEST: state_d = ST_NEST;
          default:  state_d = ST_PLAY;
        endcase
      end
      ST_NEST: state_d = ST_PLAY;
      ST_DEAD: begin
        if (dwell_done) begin
          if (lives_q == '0) begin
            state_d = ST_OVER;
          end else begin
            state_d       = ST_PLAY;
            clear_point_d = 1'b1;
          end
        end
      end
      ST_LEVEL: begin
        if (dwell_done) begin
          if (level_q == LEVEL_W'(NUM_LEVELS - 1)) begin
            state_d = ST_WIN;
          end else begin
            state_d = ST_LOAD;
            level_d = level_q + LEVEL_W'(1);
`ifdef GAMESEQ_BONUS_LIFE_EN
            lives_d = (lives_q >= LIVES_W'(MAX_LIVES)) ? LIVES_W'(MAX_LIVES)
                                                       : lives_q + LIVES_W'(1);
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Pulses are registered, so they line up with the state they belong to.
    if (state_d == ST_LOAD) begin
      clear_back_d  = 1'b1;
      clear_point_d = 1'b1;
    end
    if (state_d == ST_NEST)
      clear_point_d = 1'b1;
  end

  always_ff @(posedge GAMESEQ_CLOCK_50 or negedge GAMESEQ_RESET_InLow) begin
    if (!GAMESEQ_RESET_InLow) begin
      state_q       <= ST_IDLE;
      level_q       <= '0;
      lives_q       <= LIVES_W'(LIVES_INIT);
      speed_q       <= 8'(BASE_SPEED);
      clear_back_q  <= 1'b0;
      clear_point_q <= 1'b0;
      run_q         <= 1'b0;
      over_q        <= 1'b0;
      win_q         <= 1'b0;
      start_prev_q  <= 1'b1;
      lose_prev_q   <= 1'b0;
      win_prev_q    <= 1'b0;
      nest_prev_q   <= 1'b0;
      dwell_armed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      lives_q       <= lives_d;
      // Follows the registered level, so it trails a level change by one cycle.
      speed_q       <= speed_for_level(int'(level_q), BASE_SPEED, SPEED_STEP, MIN_SPEED);
      clear_back_q  <= clear_back_d;
      clear_point_q <= clear_point_d;
      run_q         <= (state_d == ST_PLAY);
      over_q        <= (state_d == ST_OVER);
      win_q         <= (state_d == ST_WIN);
      start_prev_q  <= gs.GAMESEQ_start_InLow;
      lose_prev_q   <= gs.GAMESEQ_lose_InHigh;
      win_prev_q    <= gs.GAMESEQ_winLevel_InHigh;
      nest_prev_q   <= gs.GAMESEQ_nest_InHigh;
      dwell_armed_q <= in_dwell;
    end
  end

  assign gs.GAMESEQ_clearBack_OutHigh  = clear_back_q;
  assign gs.GAMESEQ_clearPoint_OutHigh = clear_point_q;
  assign gs.GAMESEQ_run_OutHigh        = run_q;
  assign gs.GAMESEQ_level_Out          = level_q;
  assign gs.GAMESEQ_lives_Out          = lives_q;
  assign gs.GAMESEQ_speed_Out          = speed_q;
  assign gs.GAMESEQ_state_Out          = state_q;
  assign gs.GAMESEQ_gameOver_OutHigh   = over_q;
  assign gs.GAMESEQ_gameWin_OutHigh    = win_q;

endmodule
